// File: rtl/div_sequencer_pkg.sv
// rtl/div_sequencer_pkg.sv - state encodings and constants shared by the divider and the hazard unit
package div_sequencer_pkg;

    typedef enum logic [2:0] {
        DIV_IDLE = 3'd0,
        DIV_PREP = 3'd1,
        DIV_CALC = 3'd2,
        DIV_FIX  = 3'd3,
        DIV_DONE = 3'd4
    } div_state_t;

    localparam int          DIV_CYCLES     = 32;
    localparam logic [31:0] DIV_BY_ZERO_LO = 32'hFFFF_FFFF;

    localparam logic STALL_ON  = 1'b1;
    localparam logic STALL_OFF = 1'b0;
    localparam logic READY_ON  = 1'b1;
    localparam logic READY_OFF = 1'b0;

endpackage

// File: rtl/div_iter_step.sv
// rtl/div_iter_step.sv - one combinational radix-2 restoring divide step
module div_iter_step
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_CYCLES
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic [WIDTH-1:0] next_quo
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem < divisor, so the shifted value is below 2*divisor and the difference fits WIDTH+1 bits signed
    assign shifted  = {rem, quo[WIDTH-1]};
    assign diff     = shifted - {1'b0, divisor};
    assign next_rem = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign next_quo = {quo[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - MIPS DIV/DIVU multi-cycle sequencer; DIV_EARLY_OUT_EN adds the small-dividend early exit
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_CYCLES
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             annul_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    div_state_t       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dvs_r;
    logic             sgn_r;
    logic             qneg;
    logic             rneg;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

    assign dvd_abs = (sgn_r && dvd_r[WIDTH-1]) ? -dvd_r : dvd_r;
    assign dvs_abs = (sgn_r && dvs_r[WIDTH-1]) ? -dvs_r : dvs_r;

    div_iter_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (dvs_abs),
        .next_rem (step_rem),
        .next_quo (step_quo)
    );

    // The DONE cycle releases the hold even though the stalled pipeline still drives start_i
    assign stall_o = (resetn && start_i && state != DIV_DONE && !annul_i) ? STALL_ON : STALL_OFF;
    assign busy_o  = (state != DIV_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= DIV_IDLE;
            cnt     <= '0;
            dvd_r   <= '0;
            dvs_r   <= '0;
            sgn_r   <= 1'b0;
            qneg    <= 1'b0;
            rneg    <= 1'b0;
            rem     <= '0;
            quo     <= '0;
            hi_o    <= '0;
            lo_o    <= '0;
            ready_o <= READY_OFF;
        end else begin
            ready_o <= READY_OFF;
            if (annul_i) begin
                state <= DIV_IDLE;
            end else begin
                case (state)
                    DIV_IDLE: begin
                        if (start_i) begin
                            dvd_r <= dividend_i;
                            dvs_r <= divisor_i;
                            sgn_r <= signed_i;
                            state <= DIV_PREP;
                        end
                    end
                    DIV_PREP: begin
                        qneg <= sgn_r & (dvd_r[WIDTH-1] ^ dvs_r[WIDTH-1]);
                        rneg <= sgn_r & dvd_r[WIDTH-1];
                        if (dvs_r == '0) begin
                            lo_o    <= '1;
                            hi_o    <= dvd_r;
                            ready_o <= READY_ON;
                            state   <= DIV_DONE;
                        end
`ifdef DIV_EARLY_OUT_EN
                        else if (dvd_abs < dvs_abs) begin
                            quo   <= '0;
                            rem   <= dvd_abs;
                            state <= DIV_FIX;
                        end
`endif
                        else begin
                            quo   <= dvd_abs;
                            rem   <= '0;
                            cnt   <= LAST;
                            state <= DIV_CALC;
                        end
                    end
                    DIV_CALC: begin
                        rem <= step_rem;
                        quo <= step_quo;
                        if (cnt == '0) state <= DIV_FIX;
                        else           cnt   <= cnt - CW'(1);
                    end
                    DIV_FIX: begin
                        hi_o    <= rneg ? -rem : rem;
                        lo_o    <= qneg ? -quo : quo;
                        ready_o <= READY_ON;
                        state   <= DIV_DONE;
                    end
                    DIV_DONE: state <= DIV_IDLE;
                    default:  state <= DIV_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - scoreboard bench for div_sequencer
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start_i = 1'b0;
    logic        signed_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [31:0] dividend_i = '0;
    logic [31:0] divisor_i = '0;
    logic        stall_o;
    logic        busy_o;
    logic        ready_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    div_sequencer dut (
        .clk        (clk),
        .resetn     (resetn),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .annul_i    (annul_i),
        .stall_o    (stall_o),
        .busy_o     (busy_o),
        .ready_o    (ready_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int last_ready_cyc = -1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          rcyc;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn && ready_o) begin
                last_ready_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_ready: got ready=1 at cycle %0d want no pending result", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("hi", hi_o, e.hi);
                    check("lo", lo_o, e.lo);
                    check("ready_cycle", 32'(cyc), 32'(e.rcyc));
                end
            end
        end
    end

    task automatic drive(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        start_i    = 1'b1;
        signed_i   = sgn;
        dividend_i = a;
        divisor_i  = b;
    endtask

    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input int lat);
        exp_t e;
        drive(sgn, a, b);
        e.hi   = ehi;
        e.lo   = elo;
        e.rcyc = cyc + lat;
        exp_q.push_back(e);
    endtask

    task automatic wait_ready(input string nm, input int lat);
        int stalls = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (stall_o) stalls++;
            if (ready_o) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no ready in 200 cycles want ready", nm);
        end
        check({nm, "_stall_cycles"}, 32'(stalls), 32'(lat));
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        start_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    int c0;
    int early_lat;

    initial begin
        start_i = 1'b1;
        #12;
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_ready", {31'd0, ready_o}, 32'd0);
        check("rst_hi", hi_o, 32'd0);
        check("rst_lo", lo_o, 32'd0);
        start_i = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        issue(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 35);
        wait_ready("divu_100_7", 35);
        idle_cycle();

        issue(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 35);
        wait_ready("div_m7_2", 35);
        idle_cycle();

        issue(1'b0, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, 35);
        wait_ready("divu_fff9_2", 35);
        idle_cycle();

        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 35);
        wait_ready("div_overflow", 35);
        idle_cycle();

        issue(1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 2);
        wait_ready("divu_5_0", 2);
        idle_cycle();

        // annul in cycle 10: no result, previous HI/LO kept
        drive(1'b0, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        annul_i = 1'b1;
        #1;
        check("annul_stall", {31'd0, stall_o}, 32'd0);
        check("annul_busy_before", {31'd0, busy_o}, 32'd1);
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        start_i = 1'b0;
        check("annul_busy_after", {31'd0, busy_o}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("annul_hi_hold", hi_o, 32'd5);
        check("annul_lo_hold", lo_o, 32'hFFFF_FFFF);

        issue(1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 35);
        wait_ready("divu_9_3", 35);
        idle_cycle();

        c0 = cyc;
        issue(1'b1, 32'd20, 32'd6, 32'd2, 32'd3, 35);
        wait_ready("b2b_first", 35);
        issue(1'b1, 32'd21, 32'd4, 32'd1, 32'd5, 35);
        wait_ready("b2b_second", 35);
        check("b2b_second_ready_cycle", 32'(last_ready_cyc - c0), 32'd71);
        idle_cycle();

`ifdef DIV_EARLY_OUT_EN
        early_lat = 3;
`else
        early_lat = 35;
`endif
        issue(1'b0, 32'd3, 32'd10, 32'd3, 32'd0, early_lat);
        wait_ready("divu_3_10", early_lat);
        idle_cycle();

        // asynchronous reset in the middle of CALC
        drive(1'b0, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check("midrst_hi", hi_o, 32'd0);
        check("midrst_lo", lo_o, 32'd0);
        check("midrst_busy", {31'd0, busy_o}, 32'd0);
        check("midrst_ready", {31'd0, ready_o}, 32'd0);
        check("midrst_stall", {31'd0, stall_o}, 32'd0);
        start_i = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("pending_results", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test by 100000 time units want finish");
        $fatal(1);
    end

endmodule
